// File: rtl/alu_pkg.sv
// Shared op codes, sequencer states and op-class helpers for alu_sequencer.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;
    localparam logic [3:0] OP_NEG  = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;
    localparam logic [3:0] OP_NOR  = 4'd13;
    localparam logic [3:0] OP_NAND = 4'd14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op != 4'h0) && (op != 4'hF);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Request/response sequencer in front of the registered ALU; owns HI/LO.
// Optional ALU_SEQ_DIVZERO_EN: divide by zero is rejected like an illegal op.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MULDIV_WAIT = 2,
    parameter int DATA_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [3:0]          alu_sel,
    input  logic [2*DATA_W-1:0] alu_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_lo,
    output logic [DATA_W-1:0]   rsp_hi,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   hi_q,
    output logic [DATA_W-1:0]   lo_q,
    output logic                busy
);

    localparam logic [3:0] WAIT_LD = 4'(MULDIV_WAIT);
    localparam logic       HAS_WAIT = (MULDIV_WAIT > 0);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       accept;
    logic       bad_req;
    logic       cur_md;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign accept    = req_valid && req_ready;
    assign cur_md    = is_muldiv(alu_sel);

`ifdef ALU_SEQ_DIVZERO_EN
    assign bad_req = !is_legal(req_op) ||
                     ((req_op == OP_DIV) && (req_b == '0));
`else
    assign bad_req = !is_legal(req_op);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = bad_req ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = (cur_md && HAS_WAIT) ? S_WAIT : S_CAPT;
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nx = S_CAPT;
                end
            end
            S_CAPT: begin
                state_nx = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Settle counter only runs for mul/div; it is reloaded on every ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= WAIT_LD;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= OP_ADD;
            rsp_lo  <= '0;
            rsp_hi  <= '0;
            rsp_err <= 1'b0;
        end else if (accept) begin
            if (bad_req) begin
                rsp_lo  <= '0;
                rsp_hi  <= '0;
                rsp_err <= 1'b1;
            end else begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_sel <= req_op;
                rsp_err <= 1'b0;
            end
        end else if (state == S_CAPT) begin
            rsp_lo  <= alu_out[DATA_W-1:0];
            rsp_hi  <= cur_md ? alu_out[2*DATA_W-1:DATA_W] : '0;
            rsp_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if ((state == S_CAPT) && cur_md) begin
            hi_q <= alu_out[2*DATA_W-1:DATA_W];
            lo_q <= alu_out[DATA_W-1:0];
        end
    end

endmodule
